psum_accum_seq: RTL and testbench

- Autonomous drain/accumulate sequencer between the output FIFO and the partial-sum SRAM. It replaces the hand-driven per-cycle ofifo_rd / pmem / acc instruction bits in the core.
- Given a start pulse, base address, row count and mode, it pops OFIFO rows and read-modify-writes PSUM SRAM. Each stored word is pass-through, saturating accumulate, or saturating accumulate plus ReLU.
- It is generalised over column count, psum width and SRAM depth.

---
 rtl/psum_pkg.sv | 28 ++
 rtl/psum_accum_seq_lane_alu.sv | 39 +++
 rtl/psum_accum_seq.sv | 134 +++++++++++++
 tb/tb_psum_accum_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// psum_pkg: shared definitions for the partial-sum drain/accumulate sequencer.
//   - mode encodings for the per-row operation
//   - sequencer state encoding (also exported on the state_dbg port)
//   - saturation bounds as functions of the partial-sum width
package psum_pkg;

   localparam logic [1:0] MODE_PASS     = 2'b00;
   localparam logic [1:0] MODE_ACC      = 2'b01;
   localparam logic [1:0] MODE_ACC_RELU = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      FIN  = 2'd3
   } state_t;

   // Largest signed value of a bw-bit word, as a 64-bit pattern (bw <= 63).
   function automatic logic [63:0] sat_max(input int bw);
      return (64'd1 << (bw - 1)) - 64'd1;
   endfunction

   // Smallest signed value of a bw-bit word; its low bw bits are 100..0.
   function automatic logic [63:0] sat_min(input int bw);
      return ~sat_max(bw);
   endfunction

endpackage

// File: rtl/psum_accum_seq_lane_alu.sv
// psum_lane_alu: one lane of the row datapath (purely combinational).
//   mode   in  2        operation (pass / accumulate / accumulate+ReLU)
//   row    in  PSUM_BW  OFIFO lane value
//   psum   in  PSUM_BW  SRAM lane value read back
//   result out PSUM_BW  value to store for this lane
module psum_lane_alu
   import psum_pkg::*;
#(
   parameter int PSUM_BW = 16
) (
   input  logic [1:0]         mode,
   input  logic [PSUM_BW-1:0] row,
   input  logic [PSUM_BW-1:0] psum,
   output logic [PSUM_BW-1:0] result
);

   localparam logic [63:0] MAX64 = sat_max(PSUM_BW);
   localparam logic [63:0] MIN64 = sat_min(PSUM_BW);

   logic [PSUM_BW:0]   sum;
   logic [PSUM_BW-1:0] sat;

   always_comb begin
      // One guard bit: sum[PSUM_BW] is the true sign, and it disagrees with
      // sum[PSUM_BW-1] exactly when the PSUM_BW-bit result overflowed.
      sum = {row[PSUM_BW-1], row} + {psum[PSUM_BW-1], psum};
      if (sum[PSUM_BW] != sum[PSUM_BW-1]) begin
         sat = sum[PSUM_BW] ? MIN64[PSUM_BW-1:0] : MAX64[PSUM_BW-1:0];
      end else begin
         sat = sum[PSUM_BW-1:0];
      end
      case (mode)
         MODE_PASS:     result = row;
         MODE_ACC_RELU: result = sat[PSUM_BW-1] ? '0 : sat;
         default:       result = sat;
      endcase
   end

endmodule

// File: rtl/psum_accum_seq.sv
// psum_accum_seq: drains OFIFO rows into PSUM SRAM, one read-modify-write
// per row (RD cycle reads SRAM and pops OFIFO, WR cycle writes the result).
//   clk, reset        clock, synchronous active-low reset
//   start             request, sampled only while idle
//   mode              00 pass, 01 accumulate, 10 accumulate+ReLU, 11 as 01
//   base_addr         first SRAM row, wraps modulo 2**ADDR_W
//   num_rows          rows to process (0 .. 2**ADDR_W)
//   ofifo_valid/out   first-word-fall-through OFIFO head
//   ofifo_rd          pop strobe
//   pmem_*            single-port SRAM (cen active-low, q valid 1 cycle after read)
//   busy, done        run in progress / one-cycle completion pulse
//   sfp_out           registered copy of the last row written
//   state_dbg         current sequencer state
//
// Handshake: ofifo_valid/ofifo_rd is a valid/ready pair on a show-ahead FIFO.
// A pop happens on the rising edge where ofifo_rd=1; ofifo_rd is only ever
// high while ofifo_valid=1, and ofifo_out is captured on that same edge.
module psum_accum_seq
   import psum_pkg::*;
#(
   parameter int COL     = 8,
   parameter int PSUM_BW = 16,
   parameter int ADDR_W  = 11
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [1:0]             mode,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic [ADDR_W:0]        num_rows,
   input  logic                   ofifo_valid,
   input  logic [COL*PSUM_BW-1:0] ofifo_out,
   output logic                   ofifo_rd,
   output logic                   pmem_cen,
   output logic                   pmem_wen,
   output logic                   pmem_ren,
   output logic [ADDR_W-1:0]      pmem_a,
   output logic [COL*PSUM_BW-1:0] pmem_d,
   input  logic [COL*PSUM_BW-1:0] pmem_q,
   output logic                   busy,
   output logic                   done,
   output logic [COL*PSUM_BW-1:0] sfp_out,
   output state_t                 state_dbg
);

   state_t                 state_q;
   logic [1:0]             mode_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [ADDR_W:0]        cnt_q;
   logic [COL*PSUM_BW-1:0] row_q;
   logic [COL*PSUM_BW-1:0] result;
   logic                   rd_fire;
   logic                   wr_fire;

   for (genvar i = 0; i < COL; i++) begin : g_lane
      psum_lane_alu #(.PSUM_BW(PSUM_BW)) u_alu (
         .mode   (mode_q),
         .row    (row_q[i*PSUM_BW +: PSUM_BW]),
         .psum   (pmem_q[i*PSUM_BW +: PSUM_BW]),
         .result (result[i*PSUM_BW +: PSUM_BW])
      );
   end

   // SRAM/OFIFO strobes must follow ofifo_valid in the same cycle, so they are
   // decoded from the registered state. They are also qualified by reset so an
   // edge that resets the block cannot simultaneously write or pop.
   always_comb begin
      rd_fire  = reset && (state_q == RD) && ofifo_valid;
      wr_fire  = reset && (state_q == WR);
      ofifo_rd = rd_fire;
      pmem_cen = !(rd_fire || wr_fire);
      pmem_ren = rd_fire && (mode_q != MODE_PASS);
      pmem_wen = wr_fire;
      pmem_a   = (rd_fire || wr_fire) ? addr_q : '0;
      pmem_d   = wr_fire ? result : '0;
   end

   assign state_dbg = state_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         mode_q  <= MODE_PASS;
         addr_q  <= '0;
         cnt_q   <= '0;
         row_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sfp_out <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  // The reserved code is folded into plain accumulate here.
                  mode_q <= (mode == 2'b11) ? MODE_ACC : mode;
                  addr_q <= base_addr;
                  cnt_q  <= num_rows;
                  busy   <= 1'b1;
                  if (num_rows == '0) begin
                     state_q <= FIN;
                     done    <= 1'b1;
                  end else begin
                     state_q <= RD;
                  end
               end
            end
            RD: begin
               if (ofifo_valid) begin
                  row_q   <= ofifo_out;
                  state_q <= WR;
               end
            end
            WR: begin
               sfp_out <= result;
               addr_q  <= addr_q + ADDR_W'(1);
               cnt_q   <= cnt_q - (ADDR_W+1)'(1);
               if (cnt_q == (ADDR_W+1)'(1)) begin
                  state_q <= FIN;
                  done    <= 1'b1;
               end else begin
                  state_q <= RD;
               end
            end
            FIN: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_accum_seq.sv
// Bench for psum_accum_seq: SRAM and OFIFO models, a lane-arithmetic model
// that predicts every SRAM write, and directed runs with literal expectations.
module tb_psum_accum_seq;

   localparam int COL     = 8;
   localparam int PSUM_BW = 16;
   localparam int ADDR_W  = 11;
   localparam int ROW_W   = COL * PSUM_BW;
   localparam int W       = ADDR_W + ROW_W;
   localparam int DEPTH   = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [1:0]        mode = 2'b00;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   num_rows = '0;
   logic              ofifo_valid = 1'b0;
   logic [ROW_W-1:0]  ofifo_out = '0;
   logic              ofifo_rd;
   logic              pmem_cen;
   logic              pmem_wen;
   logic              pmem_ren;
   logic [ADDR_W-1:0] pmem_a;
   logic [ROW_W-1:0]  pmem_d;
   logic [ROW_W-1:0]  pmem_q = '0;
   logic              busy;
   logic              done;
   logic [ROW_W-1:0]  sfp_out;
   logic [1:0]        state_dbg;

   psum_accum_seq #(.COL(COL), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .base_addr(base_addr), .num_rows(num_rows),
      .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
      .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_ren(pmem_ren),
      .pmem_a(pmem_a), .pmem_d(pmem_d), .pmem_q(pmem_q),
      .busy(busy), .done(done), .sfp_out(sfp_out), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- SRAM model ----------------
   logic [ROW_W-1:0] mem [DEPTH];

   always @(posedge clk) begin
      if (!pmem_cen && pmem_ren) pmem_q <= mem[pmem_a];
      if (!pmem_cen && pmem_wen) mem[pmem_a] <= pmem_d;
   end

   // ---------------- OFIFO model (show-ahead, per-row stall delay) ----------------
   logic [ROW_W-1:0] fifo_q[$];
   int               dly_q[$];
   int               pop_cnt = 0;

   always @(posedge clk) begin
      if (ofifo_rd && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
         void'(dly_q.pop_front());
         pop_cnt++;
      end else if (dly_q.size() > 0 && dly_q[0] > 0) begin
         dly_q[0]--;
      end
      if (fifo_q.size() > 0) begin
         ofifo_valid <= (dly_q[0] == 0);
         ofifo_out   <= fifo_q[0];
      end else begin
         ofifo_valid <= 1'b0;
         ofifo_out   <= '0;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [ROW_W-1:0] model_row(input logic [1:0] m,
                                                  input logic [ROW_W-1:0] r,
                                                  input logic [ROW_W-1:0] old);
      logic [ROW_W-1:0] o;
      o = '0;
      for (int l = 0; l < COL; l++) begin
         int a;
         int b;
         int s;
         a = int'($signed(r[l*PSUM_BW +: PSUM_BW]));
         b = int'($signed(old[l*PSUM_BW +: PSUM_BW]));
         if (m == 2'b00) begin
            s = a;
         end else begin
            s = a + b;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            if (m == 2'b10 && s < 0) s = 0;
         end
         o[l*PSUM_BW +: PSUM_BW] = 16'(s);
      end
      return o;
   endfunction

   function automatic logic [ROW_W-1:0] rep(input int v);
      logic [15:0] x;
      x = 16'(v);
      return {COL{x}};
   endfunction

   function automatic logic [ROW_W-1:0] pack(input int v[8]);
      logic [ROW_W-1:0] o;
      for (int l = 0; l < COL; l++) o[l*PSUM_BW +: PSUM_BW] = 16'(v[l]);
      return o;
   endfunction

   // ---------------- scoreboard / compare process ----------------
   logic [W-1:0]     exp_q[$];
   logic [1:0]       cur_mode = 2'b00;
   int               wr_cnt = 0;
   logic [ROW_W-1:0] sfp_exp;
   bit               sfp_pend = 1'b0;

   always @(negedge clk) begin
      if (sfp_pend) begin
         check("sfp_out", 160'(sfp_out), 160'(sfp_exp));
         sfp_pend = 1'b0;
      end
      if (ofifo_rd) begin
         check("rd_when_valid", 160'(ofifo_valid), 160'(1));
         check("rd_cen", 160'(pmem_cen), 160'(0));
         check("rd_ren_by_mode", 160'(pmem_ren), 160'(cur_mode != 2'b00));
         if (exp_q.size() > 0)
            check("rd_addr", 160'(pmem_a), 160'(exp_q[0][W-1:ROW_W]));
      end
      if (!ofifo_valid && !pmem_wen)
         check("idle_ctrl", 160'({ofifo_rd, pmem_cen, pmem_ren}), 160'(3'b010));
      if (!pmem_cen && pmem_wen) begin
         wr_cnt++;
         check("wr_no_ren", 160'(pmem_ren), 160'(0));
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_unexpected: write at addr %0d data %h with none pending", pmem_a, pmem_d);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("wr_addr", 160'(pmem_a), 160'(e[W-1:ROW_W]));
            check("wr_data", 160'(pmem_d), 160'(e[ROW_W-1:0]));
            sfp_exp  = e[ROW_W-1:0];
            sfp_pend = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [ROW_W-1:0] stim[$];

   task automatic load_rows(input logic [1:0] m, input int base, input int n_exp, input int dly);
      for (int i = 0; i < stim.size(); i++) begin
         int a;
         a = (base + i) % DEPTH;
         fifo_q.push_back(stim[i]);
         dly_q.push_back(dly);
         if (i < n_exp) exp_q.push_back({ADDR_W'(a), model_row(m, stim[i], mem[11'(a)])});
      end
      stim.delete();
   endtask

   // Start a run, then scramble the request inputs to prove they were captured.
   task automatic kick(input logic [1:0] m, input int base, input int n);
      cur_mode  = m;
      mode      = m;
      base_addr = 11'(base);
      num_rows  = 12'(n);
      start     = 1'b1;
      tick();
      start     = 1'b0;
      mode      = 2'($urandom_range(0, 3));
      base_addr = 11'($urandom_range(0, DEPTH - 1));
      num_rows  = 12'($urandom_range(0, 4095));
   endtask

   // cyc = 1 means done was seen in the first cycle after the start edge.
   task automatic wait_done(input int budget, output int cyc, output bit busy_all);
      cyc = 0;
      busy_all = 1'b1;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (!busy) busy_all = 1'b0;
         if (done) begin
            cyc = c;
            break;
         end
      end
      check("done_seen", 160'(cyc != 0), 160'(1));
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"}, 160'({ofifo_rd, pmem_cen, pmem_wen, pmem_ren, busy, done}), 160'(6'b010000));
      check({tag, "_pmem_a"}, 160'(pmem_a), 160'(0));
      check({tag, "_pmem_d"}, 160'(pmem_d), 160'(0));
      check({tag, "_sfp_out"}, 160'(sfp_out), 160'(0));
      check({tag, "_state"}, 160'(state_dbg), 160'(psum_pkg::IDLE));
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int cyc;
      bit busy_all;
      int p0;
      int w0;
      int mx_m[8] = '{100, -200, 32767, -32768, 5, 0, -1, 1000};
      int mx_r[8] = '{-50, 100, 1, -1, -10, 0, 1, -2000};
      int mx_e[8] = '{50, 0, 32767, 0, 0, 0, 0, 0};

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      reset = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      reset = 1'b1;
      tick();

      // Pass mode: two rows, no SRAM reads, done five cycles after start.
      stim.push_back(rep(3));
      stim.push_back(rep(7));
      load_rows(2'b00, 5, 2, 0);
      kick(2'b00, 5, 2);
      wait_done(50, cyc, busy_all);
      check("pass_done_cycle", 160'(cyc), 160'(5));
      check("pass_mem5", 160'(mem[5]), 160'(rep(3)));
      check("pass_mem6", 160'(mem[6]), 160'(rep(7)));
      check("pass_drained", 160'(exp_q.size()), 160'(0));

      // Accumulate: 100 + (-30) = 70 in every lane.
      mem[0] = rep(100);
      p0 = pop_cnt;
      stim.push_back(rep(-30));
      load_rows(2'b01, 0, 1, 0);
      kick(2'b01, 0, 1);
      wait_done(50, cyc, busy_all);
      check("acc_mem0", 160'(mem[0]), 160'(rep(70)));
      check("acc_pops", 160'(pop_cnt - p0), 160'(1));
      check("acc_sfp_out", 160'(sfp_out), 160'(rep(70)));

      // Positive saturation.
      mem[10] = rep(32000);
      stim.push_back(rep(1000));
      load_rows(2'b01, 10, 1, 0);
      kick(2'b01, 10, 1);
      wait_done(50, cyc, busy_all);
      check("sat_pos", 160'(mem[10]), 160'(rep(32767)));

      // Reserved mode behaves as accumulate; negative saturation.
      mem[12] = rep(-32000);
      stim.push_back(rep(-1000));
      load_rows(2'b11, 12, 1, 0);
      kick(2'b11, 12, 1);
      wait_done(50, cyc, busy_all);
      check("sat_neg_mode11", 160'(mem[12]), 160'(rep(-32768)));

      // ReLU of a saturated negative sum.
      mem[20] = rep(-32000);
      stim.push_back(rep(-1000));
      load_rows(2'b10, 20, 1, 0);
      kick(2'b10, 20, 1);
      wait_done(50, cyc, busy_all);
      check("relu_zero", 160'(mem[20]), 160'(0));

      // Mixed lanes, each saturated/rectified on its own.
      mem[30] = pack(mx_m);
      stim.push_back(pack(mx_r));
      load_rows(2'b10, 30, 1, 0);
      kick(2'b10, 30, 1);
      wait_done(50, cyc, busy_all);
      check("mixed_lanes", 160'(mem[30]), 160'(pack(mx_e)));

      // OFIFO stalls plus address wrap 2047 -> 0.
      mem[2047] = rep(10);
      stim.push_back(rep(1));
      stim.push_back(rep(2));
      load_rows(2'b01, 2047, 2, 5);
      kick(2'b01, 2047, 2);
      wait_done(100, cyc, busy_all);
      check("wrap_busy_held", 160'(busy_all), 160'(1));
      check("wrap_mem2047", 160'(mem[2047]), 160'(rep(11)));
      check("wrap_mem0", 160'(mem[0]), 160'(rep(72)));
      check("wrap_stall_len", 160'(cyc), 160'(13));

      // Zero rows: immediate done, no activity.
      p0 = pop_cnt;
      w0 = wr_cnt;
      kick(2'b01, 100, 0);
      wait_done(20, cyc, busy_all);
      check("zero_done_cycle", 160'(cyc), 160'(1));
      check("zero_pops", 160'(pop_cnt - p0), 160'(0));
      check("zero_writes", 160'(wr_cnt - w0), 160'(0));

      // Start while busy is ignored.
      w0 = wr_cnt;
      stim.push_back(rep(4));
      stim.push_back(rep(5));
      stim.push_back(rep(6));
      load_rows(2'b00, 40, 3, 0);
      kick(2'b00, 40, 3);
      tick();
      mode = 2'b01;
      base_addr = 11'd60;
      num_rows = 12'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(50, cyc, busy_all);
      repeat (4) tick();
      check("busy_start_writes", 160'(wr_cnt - w0), 160'(3));
      check("busy_start_mem60", 160'(mem[60]), 160'(0));
      check("busy_start_idle", 160'(busy), 160'(0));
      check("busy_start_mem42", 160'(mem[42]), 160'(rep(6)));

      // Reset during the WR cycle of row 2 of 4.
      p0 = pop_cnt;
      stim.push_back(rep(9));
      stim.push_back(rep(10));
      stim.push_back(rep(11));
      stim.push_back(rep(12));
      load_rows(2'b00, 80, 1, 0);
      kick(2'b00, 80, 4);
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_reset_outputs("midrun");
      reset = 1'b1;
      repeat (5) tick();
      check("midrun_pops", 160'(pop_cnt - p0), 160'(2));
      check("midrun_mem80", 160'(mem[80]), 160'(rep(9)));
      check("midrun_mem81", 160'(mem[81]), 160'(0));
      check("midrun_drained", 160'(exp_q.size()), 160'(0));
      fifo_q.delete();
      dly_q.delete();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end

endmodule
